// File: rtl/seq_player.sv
// Expands a latched seed into 16 two-bit colours and plays the first `round` of them on one-hot LEDs.
// Optional macro SEQ_LFSR_EN replaces direct seed slicing with a 16-cycle Galois LFSR expansion.
module seq_player #(
   parameter int ON_CYCLES  = 12_500_000,
   parameter int GAP_CYCLES = 6_250_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] seed,
   input  logic        load,
   input  logic        start,
   input  logic [4:0]  round,
   output logic        busy,
   output logic [3:0]  led,
   output logic        done,
   input  logic [3:0]  q_idx,
   output logic [1:0]  q_color
);
   localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

`ifdef SEQ_LFSR_EN
   typedef enum logic [2:0] {IDLE, ON, GAP, FIN, EXPAND} state_t;
   logic [31:0] lfsr_q, lfsr_d;
`else
   typedef enum logic [2:0] {IDLE, ON, GAP, FIN} state_t;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [4:0]        step_q, step_d;
   logic [4:0]        r_q, r_d;
   logic [15:0][1:0]  colour_q, colour_d;
   logic [3:0]        led_q, led_d;
   logic              done_q, done_d;
   logic [1:0]        q_color_q, q_color_d;
   logic [4:0]        r_clamp;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      step_d    = step_q;
      r_d       = r_q;
      colour_d  = colour_q;
`ifdef SEQ_LFSR_EN
      lfsr_d    = lfsr_q;
`endif
      r_clamp   = (round > 5'd16) ? 5'd16 : round;
      q_color_d = colour_q[q_idx];

      case (state_q)
         IDLE: begin
            // load wins over a simultaneous start
            if (load) begin
`ifdef SEQ_LFSR_EN
               lfsr_d  = (seed == 32'h0) ? 32'h0000_0001 : seed;
               step_d  = 5'd0;
               state_d = EXPAND;
`else
               colour_d = seed;
`endif
            end else if (start) begin
               r_d    = r_clamp;
               step_d = 5'd0;
               if (r_clamp == 5'd0) begin
                  state_d = FIN;
               end else begin
                  state_d = ON;
                  timer_d = ON_LOAD;
               end
            end
         end
         ON: begin
            if (timer_q == '0) begin
               state_d = GAP;
               timer_d = GAP_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         GAP: begin
            if (timer_q == '0) begin
               if (step_q == r_q - 5'd1) begin
                  state_d = FIN;
               end else begin
                  step_d  = step_q + 5'd1;
                  state_d = ON;
                  timer_d = ON_LOAD;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         FIN: state_d = IDLE;
`ifdef SEQ_LFSR_EN
         EXPAND: begin
            colour_d[step_q[3:0]] = lfsr_q[1:0];
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
            if (step_q == 5'd15) begin
               state_d = IDLE;
            end else begin
               step_d = step_q + 5'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // led/done are registered from the next state so they align with the state they describe
      led_d  = (state_d == ON) ? (4'b0001 << colour_q[step_d[3:0]]) : 4'b0000;
      done_d = (state_d == FIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         step_q    <= '0;
         r_q       <= '0;
         colour_q  <= '0;
         led_q     <= '0;
         done_q    <= 1'b0;
         q_color_q <= '0;
`ifdef SEQ_LFSR_EN
         lfsr_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         step_q    <= step_d;
         r_q       <= r_d;
         colour_q  <= colour_d;
         led_q     <= led_d;
         done_q    <= done_d;
         q_color_q <= q_color_d;
`ifdef SEQ_LFSR_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   assign busy    = (state_q != IDLE);
   assign led     = led_q;
   assign done    = done_q;
   assign q_color = q_color_q;
endmodule

// File: tb/tb_seq_player.sv
// Randomized bench for seq_player against a per-cycle expected LED trace built from the stored colours.
module tb_seq_player;
   localparam int ON  = 4;
   localparam int GAP = 2;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] seed  = '0;
   logic        load  = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  round = '0;
   logic        busy;
   logic [3:0]  led;
   logic        done;
   logic [3:0]  q_idx = '0;
   logic [1:0]  q_color;

   int total = 0;
   int bad   = 0;
   int mdl_col [16];

   always #5 clk = ~clk;

   seq_player #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .seed(seed), .load(load), .start(start),
      .round(round), .busy(busy), .led(led), .done(done),
      .q_idx(q_idx), .q_color(q_color)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_load(input logic [31:0] s);
`ifdef SEQ_LFSR_EN
      logic [31:0] l;
      l = (s == 32'h0) ? 32'h1 : s;
      for (int i = 0; i < 16; i++) begin
         mdl_col[i] = int'(l & 32'h3);
         l = (l >> 1) ^ ((l & 32'h1) != 0 ? 32'h8020_0003 : 32'h0);
      end
`else
      for (int i = 0; i < 16; i++) mdl_col[i] = int'((s >> (2 * i)) & 32'h3);
`endif
   endtask

   task automatic do_load(input logic [31:0] s, input logic also_start);
      seed  = s;
      load  = 1'b1;
      start = also_start;
      round = 5'd3;
      tick();
      load  = 1'b0;
      start = 1'b0;
      model_load(s);
`ifdef SEQ_LFSR_EN
      for (int i = 0; i < 16; i++) begin
         check("expand_busy", busy, 1);
         tick();
      end
`endif
      check("load_busy", busy, 0);
      check("load_led", led, 0);
   endtask

   task automatic lookup_all(input string tag);
      for (int i = 0; i < 16; i++) begin
         q_idx = 4'(i);
         tick();
         check($sformatf("%s[%0d]", tag, i), q_color, mdl_col[i]);
      end
   endtask

   task automatic play(input logic [4:0] rnd, input bit disturb);
      int r;
      int exp_led[$];
      r = (rnd > 16) ? 16 : int'(rnd);
      for (int k = 0; k < r; k++) begin
         repeat (ON)  exp_led.push_back(1 << mdl_col[k]);
         repeat (GAP) exp_led.push_back(0);
      end
      round = rnd;
      start = 1'b1;
      tick();
      start = 1'b0;
      foreach (exp_led[c]) begin
         check("play_led", led, exp_led[c]);
         check("play_done_early", done, 0);
         check("play_busy", busy, 1);
         check("play_lookup", q_color, mdl_col[q_idx]);
         if (disturb && ($urandom_range(0, 3) == 0)) begin
            start = 1'($urandom);
            load  = 1'($urandom);
            seed  = $urandom;
            round = 5'($urandom);
            q_idx = 4'($urandom);
         end else begin
            start = 1'b0;
            load  = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      load  = 1'b0;
      check("done_pulse", done, 1);
      check("done_led", led, 0);
      tick();
      check("done_clear", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      int lfsr_exp[4];
      for (int i = 0; i < 16; i++) mdl_col[i] = 0;

      // reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         seed  = $urandom;
         load  = 1'($urandom);
         start = 1'($urandom);
         round = 5'($urandom);
         q_idx = 4'($urandom);
         tick();
         check("rst_led", led, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_qcolor", q_color, 0);
      end
      load  = 1'b0;
      start = 1'b0;
      reset = 1'b1;
      lookup_all("reset_lookup");

      do_load(32'h1B1B_1B1B, 1'b0);
      play(5'd4, 1'b0);
      play(5'd0, 1'b0);
      do_load(32'hFFFF_FFFF, 1'b0);
      play(5'd20, 1'b0);

      // load and start together: only the load takes effect
      do_load($urandom, 1'b1);
      lookup_all("prio_lookup");

      do_load($urandom, 1'b0);
      play(5'($urandom_range(1, 16)), 1'b1);
      lookup_all("ignored_lookup");

      // reset during step-2 ON phase
      do_load(32'h1B1B_1B1B, 1'b0);
      round = 5'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (13) tick();
      check("pre_reset_led", led, 32'(1 << mdl_col[2]));
      reset = 1'b0;
      #1;
      check("midrst_led", led, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midrst_nodone", done, 0);
      end
      reset = 1'b1;
      for (int i = 0; i < 16; i++) mdl_col[i] = 0;
      lookup_all("midrst_lookup");
      do_load(32'h1B1B_1B1B, 1'b0);
      play(5'd4, 1'b0);

      for (int n = 0; n < 5; n++) begin
         do_load($urandom, 1'b0);
         play(5'($urandom_range(0, 31)), 1'b1);
         lookup_all("rand_lookup");
      end

`ifdef SEQ_LFSR_EN
      lfsr_exp = '{1, 3, 2, 1};
      do_load(32'h0000_0001, 1'b0);
      for (int i = 0; i < 4; i++) begin
         q_idx = 4'(i);
         tick();
         check("lfsr_seed1", q_color, lfsr_exp[i]);
      end
      do_load(32'h0000_0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         q_idx = 4'(i);
         tick();
         check("lfsr_seed0", q_color, lfsr_exp[i]);
      end
`else
      lfsr_exp = '{0, 0, 0, 0};
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Stage directly downstream of the 32-bit seed generator in the Simon Says datapath.
- Latches a seed and expands it into a 16-step colour sequence, 2 bits per step.
- On command from the game FSM, plays the first `round` steps on four one-hot LEDs with fixed on and gap timing.
- Provides a registered lookup port so the input checker can compare player presses against step N.

Parameters:
- ON_CYCLES, 12_500_000, clock cycles each step's LED is lit (≥1).
- GAP_CYCLES, 6_250_000, clock cycles of all-LEDs-dark after each step (≥1).
- CNT_W, $clog2(max(ON_CYCLES,GAP_CYCLES)+1), timer width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately.
- seed  in  32  seed word from the seed generator.
- load  in  1  capture seed into the sequence store; ignored while busy.
- start  in  1  begin playback of steps 0..round-1; ignored while busy.
- round  in  5  number of steps to play; valid range 0..16.
- busy  out  1  high whenever state != IDLE.
- led  out  4  one-hot colour output; 4'b0000 when dark.
- done  out  1  one-cycle pulse at end of playback.
- q_idx  in  4  lookup step index.
- q_color  out  2  colour of step q_idx, registered (1-cycle latency).

Behaviour:
- Reset values: state=IDLE; busy=0; led=0; done=0; q_color=0; all 16 stored colours=0; timer=0; step=0; latched round=0. Reset mid-playback aborts immediately with no done pulse.
- Storage: 16 x 2-bit colour registers. Without the macro, load in IDLE writes colour[i] = seed[2i+1:2i] in one cycle; the new values are visible the next cycle.
- States: IDLE, ON, GAP, FIN (plus EXPAND under the macro).
- IDLE with start=1: latch r = min(round,16), step=0.
  - r=0 -> FIN.
  - Otherwise -> ON with timer=ON_CYCLES-1.
- If start and load are both high in IDLE, load takes priority and start is dropped.
- ON: led = 1 << colour[step].
  - timer counts down.
  - At timer==0 -> GAP with timer=GAP_CYCLES-1.
- GAP: led = 0.
  - At timer==0: if step==r-1 -> FIN; else step+1 -> ON.
- FIN: done=1 for exactly one cycle, led=0 -> IDLE.
- Timing: with start sampled at edge t, led is lit during cycles t+1..t+ON_CYCLES. Each step occupies ON_CYCLES+GAP_CYCLES cycles. done is high in cycle t+r*(ON_CYCLES+GAP_CYCLES)+1, or t+1 when r=0.
- Step counter and round compare are 5 bits wide, so r=16 does not wrap.
- round values 17..31 are clamped to 16.
- round is sampled only at start; changes during playback have no effect.
- Lookup: q_color <= colour[q_idx] every clock, independent of state, including during playback.
- led and done are driven from registers, with no combinational path from any input.

Optional Feature:
- Macro SEQ_LFSR_EN.
- Defined:
  - load in IDLE seeds a 32-bit Galois LFSR with seed, replaced by 32'h0000_0001 if seed==0.
  - The block then enters EXPAND for 16 cycles with busy=1. In cycle i it writes colour[i] = lfsr[1:0], then steps the LFSR: lsb=lfsr[0]; lfsr = (lfsr>>1) ^ (lsb ? 32'h8020_0003 : 0).
  - At the end of EXPAND it returns to IDLE.
  - start during EXPAND is ignored.
- Undefined: direct slicing as above; no EXPAND state and no LFSR logic.

Test Plan:
- Reset/idle: hold reset=0 with random inputs -> led=0, busy=0, done=0, q_color=0. Release reset; query q_idx=0..15 -> q_color=0 one cycle after each.
- Basic playback (ON=4, GAP=2): load seed=32'h1B1B_1B1B, start with round=4 -> led 1000 x4, 0000 x2, 0100 x4, 0000 x2, 0010 x4, 0000 x2, 0001 x4, 0000 x2. done pulses once, 25 cycles after start; busy then returns to 0.
- Boundaries:
  - round=0 -> done the cycle after start, led never lit.
  - round=20 with seed=32'hFFFF_FFFF -> 16 steps of led=1000, done at cycle 97.
- Ignored commands: during playback, pulse start, pulse load with a new seed, and change round -> sequence and timing unchanged, stored colours unchanged (checked via lookup).
- Reset mid-playback: assert reset during the step-2 ON phase -> led=0 and busy=0 immediately, no done pulse; a subsequent load/start replays correctly.
- SEQ_LFSR_EN: load seed=32'h0000_0001 -> busy for 16 cycles; lookup gives colours 1,3,2,1 at steps 0..3. load seed=0 -> same colours as seed=1.
